// File: rtl/selector41_arb.sv
// selector41_arb: round-robin arbiter sharing one 4-to-1, 4-bit selector
// among four requesters. Each grant is capped at HOLD consecutive cycles.
// The selected word is registered with a valid flag one cycle after the grant.
module selector41_arb #(
  parameter int HOLD = 4
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [3:0] iReq,
  input  logic [3:0] iC0,
  input  logic [3:0] iC1,
  input  logic [3:0] iC2,
  input  logic [3:0] iC3,
  output logic [3:0] oGnt,
  output logic       oS0,
  output logic       oS1,
  output logic [3:0] oZ,
  output logic       oValid
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [3:0] HOLD_C = 4'(HOLD);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_g;
  logic [3:0] r_cnt;
  logic [3:0] r_gnt;
  logic [3:0] r_z;
  logic       r_valid;

  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_any;
  logic       w_keep;
  logic [3:0] w_sel_data;

  // Arbitration: first set request bit scanning from r_ptr upward, mod 4.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_win   = r_ptr;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && iReq[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_any  = |iReq;
  // The current owner keeps the selector only while it still asks and its budget is not spent.
  assign w_keep = (r_state == ST_GRANT) && iReq[r_g] && (r_cnt < HOLD_C);

  // Grant FSM: extend, hand over (zero-gap re-arbitration), or fall back to idle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_g     <= 2'd0;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'b0000;
    end else if (w_keep) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_cnt <= r_cnt + 4'd1;
    end else if (w_any) begin
      // A fresh grant restarts the budget even when the same requester wins again.
      r_state <= ST_GRANT;
      r_g     <= w_win;
      r_cnt   <= 4'd1;
      r_ptr   <= w_win + 2'd1;
      r_gnt   <= 4'b0001 << w_win;
    end else begin
      // Select lines (r_g) intentionally hold their last value while idle.
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
    end
  end

  // Selector datapath driven by the registered select lines.
  always_comb begin
    w_sel_data = iC0;
    case (r_g)
      2'd0:    w_sel_data = iC0;
      2'd1:    w_sel_data = iC1;
      2'd2:    w_sel_data = iC2;
      default: w_sel_data = iC3;
    endcase
  end

  // Output register: captures the owner's word one cycle behind the grant.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_z     <= 4'b0000;
      r_valid <= 1'b0;
    end else begin
      r_valid <= |r_gnt;
      r_z     <= (|r_gnt) ? w_sel_data : 4'b0000;
    end
  end

  assign oGnt   = r_gnt;
  assign oS0    = r_g[0];
  assign oS1    = r_g[1];
  assign oZ     = r_z;
  assign oValid = r_valid;

endmodule

// File: tb/tb_selector41_arb.sv
// Testbench for selector41_arb: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_selector41_arb;

  localparam int HOLD = 4;

  logic       iCLK;
  logic       iRST;
  logic [3:0] iReq;
  logic [3:0] iC0, iC1, iC2, iC3;
  logic [3:0] oGnt;
  logic       oS0, oS1;
  logic [3:0] oZ;
  logic       oValid;

  int n_checks;
  int n_fail;

  // Behavioural model state
  bit m_grant;
  int m_owner;
  int m_cnt;
  int m_ptr;
  int m_z;
  bit m_valid;

  selector41_arb #(.HOLD(HOLD)) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iReq  (iReq),
    .iC0   (iC0),
    .iC1   (iC1),
    .iC2   (iC2),
    .iC3   (iC3),
    .oGnt  (oGnt),
    .oS0   (oS0),
    .oS1   (oS1),
    .oZ    (oZ),
    .oValid(oValid)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = 0;
    m_owner = 0;
    m_cnt   = 0;
    m_ptr   = 0;
    m_z     = 0;
    m_valid = 0;
  endtask

  // One rising edge of the reference: data stage uses the pre-edge owner,
  // then the grant rules are applied to the sampled request vector.
  task automatic model_edge();
    int words[4];
    int req;
    words[0] = int'(iC0);
    words[1] = int'(iC1);
    words[2] = int'(iC2);
    words[3] = int'(iC3);
    req      = int'(iReq);
    m_valid  = m_grant;
    m_z      = m_grant ? words[m_owner] : 0;
    if (m_grant && ((req >> m_owner) & 1) == 1 && m_cnt < HOLD) begin
      m_cnt = m_cnt + 1;
    end else if (req != 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (((req >> idx) & 1) == 1) begin
          m_owner = idx;
          break;
        end
      end
      m_grant = 1;
      m_cnt   = 1;
      m_ptr   = (m_owner + 1) % 4;
    end else begin
      m_grant = 0;
    end
  endtask

  task automatic compare(input string where);
    check({where, ".gnt"},   32'(oGnt),        m_grant ? (32'd1 << m_owner) : 32'd0);
    check({where, ".sel"},   32'({oS1, oS0}),  32'(m_owner));
    check({where, ".z"},     32'(oZ),          32'(m_z));
    check({where, ".valid"}, 32'(oValid),      32'(m_valid));
  endtask

  // Starts and ends on a falling edge: drive, clock, model, compare.
  task automatic step(input string where, input logic [3:0] req,
                      input logic [3:0] c0, input logic [3:0] c1,
                      input logic [3:0] c2, input logic [3:0] c3);
    iReq = req;
    iC0  = c0;
    iC1  = c1;
    iC2  = c2;
    iC3  = c3;
    @(posedge iCLK);
    model_edge();
    #1;
    compare(where);
    @(negedge iCLK);
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    model_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    iRST = 1'b1;
    iReq = 4'b0000;
    iC0  = 4'h1;
    iC1  = 4'h2;
    iC2  = 4'h4;
    iC3  = 4'h8;
    model_reset();
    @(negedge iCLK);
    @(negedge iCLK);
    compare("reset");
    iRST = 1'b0;

    // Reset mid-grant under full contention, then first grant after release
    for (int i = 0; i < 3; i++) step("pre_rst", 4'b1111, 4'h1, 4'h2, 4'h4, 4'h8);
    #2 iRST = 1'b1;
    #1;
    model_reset();
    compare("async_rst");
    check("async_rst.gnt_zero", 32'(oGnt), 32'd0);
    #1 iRST = 1'b0;
    step("post_rst", 4'b1111, 4'h1, 4'h2, 4'h4, 4'h8);
    check("post_rst.first_gnt", 32'(oGnt), 32'b0001);

    // Sole requester 2: continuous grant past HOLD with no gap
    do_reset();
    step("sole", 4'b0100, 4'h0, 4'h0, 4'b0100, 4'h0);
    check("sole.gnt", 32'(oGnt), 32'b0100);
    check("sole.sel", 32'({oS1, oS0}), 32'd2);
    for (int i = 0; i < 7; i++) step("sole", 4'b0100, 4'h0, 4'h0, 4'b0100, 4'h0);
    check("sole.z", 32'(oZ), 32'b0100);

    // Full contention: 0001,0010,0100,1000,0001 each held HOLD cycles
    do_reset();
    for (int i = 0; i < 4 * HOLD + 1; i++) begin
      step("contend", 4'b1111, 4'h1, 4'h2, 4'h4, 4'h8);
      check("contend.seq", 32'(oGnt), 32'd1 << ((i / HOLD) % 4));
    end

    // Early release by owner 0 with requester 3 waiting
    do_reset();
    step("early", 4'b1001, 4'h5, 4'h6, 4'h7, 4'h9);
    step("early", 4'b1001, 4'h5, 4'h6, 4'h7, 4'h9);
    step("early", 4'b1000, 4'h5, 4'h6, 4'h7, 4'h9);
    check("early.handover", 32'(oGnt), 32'b1000);
    for (int i = 0; i < HOLD - 1; i++) step("early", 4'b1000, 4'h5, 4'h6, 4'h7, 4'h9);

    // Pointer fairness: after owner 3 expires, 1010 goes to 1, then to 3
    step("fair", 4'b1010, 4'h5, 4'h6, 4'h7, 4'h9);
    check("fair.first", 32'(oGnt), 32'b0010);
    for (int i = 0; i < HOLD - 1; i++) step("fair", 4'b1010, 4'h5, 4'h6, 4'h7, 4'h9);
    step("fair", 4'b1010, 4'h5, 4'h6, 4'h7, 4'h9);
    check("fair.second", 32'(oGnt), 32'b1000);

    // Idle return: grant drops, valid follows one edge later, selects hold
    step("idle", 4'b0000, 4'h5, 4'h6, 4'h7, 4'h9);
    check("idle.gnt", 32'(oGnt), 32'd0);
    check("idle.valid_lag", 32'(oValid), 32'd1);
    step("idle", 4'b0000, 4'h5, 4'h6, 4'h7, 4'h9);
    check("idle.valid", 32'(oValid), 32'd0);
    check("idle.sel_hold", 32'({oS1, oS0}), 32'd3);

    // Random traffic: requests change occasionally so grants run to expiry too
    begin
      logic [3:0] req;
      req = 4'b0000;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
        step("rand", req, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/selector41_arb.md
# selector41_arb

Round-robin arbiter that shares one 4-to-1, 4-bit selector datapath among four requesters. It decides which requester owns the selector and drives the select lines. It also registers the selected 4-bit word with a valid flag for the downstream consumer. Each grant is limited to a fixed number of cycles so no requester can starve the others.

## Interface
- HOLD, default 4: maximum consecutive cycles one grant lasts; legal range 1..15.
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iReq  in  4  request vector; bit n = requester n wants the selector.
- iC0, iC1, iC2, iC3  in  4 each  data word of requester 0..3.
- oGnt  out  4  one-hot current grant; 0000 when idle.
- oS0, oS1  out  1 each  selector lines; {oS1,oS0} = index of granted requester.
- oZ  out  4  registered selected data word.
- oValid  out  1  oZ holds data from a granted requester.

## Operation
- State: an FSM with IDLE and GRANT.
  - ptr[1:0]: round-robin start index.
  - cnt[3:0]: counts cycles in the current grant.
  - g[1:0]: current owner.
- Arbitration function: the first set bit of iReq, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - iReq = 0000: stay IDLE.
  - Otherwise: grant the arbitration winner w, then g<=w, cnt<=1, ptr<=w+1 mod 4, go to GRANT.
- GRANT, each edge:
  - If iReq[g]=1 and cnt<HOLD: keep the grant, cnt<=cnt+1.
  - If iReq[g]=0 or cnt=HOLD: re-arbitrate at the same edge, with no idle gap.
    - Any request present: new winner per the arbitration function. cnt<=1 even if the same requester wins again (the sole requester is re-granted).
    - No request present: go to IDLE, oGnt<=0000.
- Because ptr=g+1 after a grant, an expiring owner is served last among the current requesters.
- Outputs:
  - oGnt = one-hot(g) in GRANT, 0000 in IDLE.
  - {oS1,oS0} = g in GRANT; holds its last value in IDLE.
- Datapath register, updated each edge:
  - oValid <= (oGnt != 0000).
  - oZ <= iC selected by {oS1,oS0} when oGnt != 0000, else 0000.
- Selection mapping: 00→iC0, 01→iC1, 10→iC2, 11→iC3.
- Reset (asynchronous, any time, including mid-grant):
  - State IDLE, ptr=0, cnt=0, g=0.
  - oGnt=0000, oS0=oS1=0, oZ=0000, oValid=0.
  - An in-flight grant is dropped; it is not resumed after reset.

## Timing
- Request to grant: iReq sampled at edge k → oGnt/oS valid after edge k.
- Grant to data: oZ/oValid follow oGnt by exactly one cycle.
  - Data sampled at edge k+1 from iC of the owner → oZ valid after edge k+1.
- Minimum grant length: 1 cycle (owner drops iReq immediately). Maximum: HOLD cycles.
- Grant handover takes zero idle cycles. oGnt changes directly from old to new one-hot and is never 0000 between them while requests are pending.
- oValid deasserts one cycle after oGnt becomes 0000.
- A requester deasserting iReq in the same cycle its grant would expire behaves as a release. Both cases are identical: re-arbitrate.
- New requests arriving mid-grant do not preempt; they wait for release or expiry.
- Worst-case wait for a continuously asserted request: 3×HOLD cycles.

## Test plan
- Reset:
  - Assert iRST mid-grant (iReq=1111) → all outputs 0 asynchronously, before the next edge.
  - Release iRST with iReq=1111 → first grant is 0001.
- Sole requester, HOLD=4, iC2=0100, iReq=0100:
  - oGnt=0100 and {oS1,oS0}=10 after the first edge; oZ=0100, oValid=1 one cycle later.
  - Grant continuous past 4 cycles with no gap.
- Full contention, iReq=1111, iC0..iC3=0001/0010/0100/1000:
  - oGnt sequence 0001, 0010, 0100, 1000, 0001, with each held 4 cycles.
  - oZ follows the same sequence one cycle later.
- Early release:
  - Owner 0 drops iReq[0] after 2 cycles while iReq[3]=1 → oGnt=1000 at the next edge.
  - cnt restarts; owner 3 holds 4 cycles.
- Pointer fairness:
  - After a grant to 3 expires, iReq=1010 → grant 0010 (ptr=0, first set bit is 1).
  - Then after expiry → grant 1000.
- Idle return:
  - All requests drop → oGnt=0000 next edge, oValid=0 one edge later, oZ=0000.
  - {oS1,oS0} holds its last value.
